// File: rtl/e_fwd_operand.sv
// rtl/e_fwd_operand.sv - E-stage operand forwarding unit with stall hold register
//
// Purpose: picks the E-stage source operand from the ID/EX value or one of
//   NSRC prioritised in-flight results (index 0 nearest). It requests a
//   load-use stall when the nearest producer is not ready. While E is frozen
//   it keeps the last forwarded value, so a result that retires during the
//   stall is not lost.
// Optional feature: define E_FWD_STAT_EN to build the event counters;
//   otherwise fwd_count and stall_count read 0.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   e_stall, e_flush E stage held / flushed this cycle (flush wins)
//   e_src_addr       source register address of the E instruction
//   e_reg_val        register-file value carried in ID/EX
//   fwd_we/addr/data/ready  per-source write enable, destination, result, result valid
//   operand, sel     selected operand and its origin (0 reg, i+1 source i, NSRC+1 held)
//   hazard_stall     stall request to the hazard unit
//   held_valid       hold register occupied
//   fwd_count, stall_count  event counters
module e_fwd_operand #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2,
  localparam int SEL_W = $clog2(NSRC + 2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   e_stall,
  input  logic                   e_flush,
  input  logic [ADDR_W-1:0]      e_src_addr,
  input  logic [DATA_W-1:0]      e_reg_val,
  input  logic [NSRC-1:0]        fwd_we,
  input  logic [NSRC*ADDR_W-1:0] fwd_addr,
  input  logic [NSRC*DATA_W-1:0] fwd_data,
  input  logic [NSRC-1:0]        fwd_ready,
  output logic [DATA_W-1:0]      operand,
  output logic [SEL_W-1:0]       sel,
  output logic                   hazard_stall,
  output logic                   held_valid,
  output logic [31:0]            fwd_count,
  output logic [31:0]            stall_count
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_state_t;

  hold_state_t       state, state_next;
  logic [DATA_W-1:0] held;
  logic              win_found;
  logic              win_ready;
  logic [SEL_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
  logic              capture;

  // Scan from the farthest source down so the nearest match is written last.
  // Register 0 never matches.
  always_comb begin
    win_found = 1'b0;
    win_ready = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_addr[i*ADDR_W +: ADDR_W] == e_src_addr &&
          e_src_addr != '0) begin
        win_found = 1'b1;
        win_ready = fwd_ready[i];
        win_idx   = SEL_W'(i);
        win_data  = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Live ready data always refreshes the hold while E is frozen.
  assign capture = e_stall && !e_flush && win_found && win_ready;

  // Hold FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Hold FSM: next state
  always_comb begin
    state_next = state;
    if (!e_stall || e_flush) state_next = EMPTY;
    else if (capture)        state_next = HELD;
  end

  // Hold data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        held <= '0;
    else if (capture) held <= win_data;
  end

  // Hold FSM: outputs
  always_comb begin
    held_valid   = (state == HELD);
    hazard_stall = 1'b0;
    operand      = e_reg_val;
    sel          = '0;
    if (win_found && win_ready) begin
      operand = win_data;
      sel     = win_idx + SEL_W'(1);
    end else begin
      // Unready winner or no match: fall back to the hold, then ID/EX.
      hazard_stall = win_found;
      if (state == HELD) begin
        operand = held;
        sel     = SEL_W'(NSRC + 1);
      end
    end
  end

`ifdef E_FWD_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (!e_stall && !e_flush && sel != '0) fwd_count <= fwd_count + 32'd1;
      if (hazard_stall) stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign fwd_count   = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_e_fwd_operand.sv
// tb/tb_e_fwd_operand.sv - directed self-checking bench for e_fwd_operand
module tb_e_fwd_operand;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NSRC   = 2;
  localparam int SEL_W  = $clog2(NSRC + 2);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   e_stall;
  logic                   e_flush;
  logic [ADDR_W-1:0]      e_src_addr;
  logic [DATA_W-1:0]      e_reg_val;
  logic [NSRC-1:0]        fwd_we;
  logic [NSRC*ADDR_W-1:0] fwd_addr;
  logic [NSRC*DATA_W-1:0] fwd_data;
  logic [NSRC-1:0]        fwd_ready;
  logic [DATA_W-1:0]      operand;
  logic [SEL_W-1:0]       sel;
  logic                   hazard_stall;
  logic                   held_valid;
  logic [31:0]            fwd_count;
  logic [31:0]            stall_count;

  int vectors = 0;
  int miscompares = 0;

`ifdef E_FWD_STAT_EN
  localparam logic [31:0] EXP_FWD   = 32'd4;
  localparam logic [31:0] EXP_STALL = 32'd2;
`else
  localparam logic [31:0] EXP_FWD   = 32'd0;
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  e_fwd_operand #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .e_stall(e_stall), .e_flush(e_flush),
    .e_src_addr(e_src_addr), .e_reg_val(e_reg_val), .fwd_we(fwd_we),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .operand(operand), .sel(sel), .hazard_stall(hazard_stall),
    .held_valid(held_valid), .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] op, input logic [1:0] s,
                         input logic hs, input logic hv);
    chk({tag, ".operand"}, 64'(operand), 64'(op));
    chk({tag, ".sel"}, 64'(sel), 64'(s));
    chk({tag, ".hazard_stall"}, 64'(hazard_stall), 64'(hs));
    chk({tag, ".held_valid"}, 64'(held_valid), 64'(hv));
  endtask

  task automatic set_src(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic rdy);
    fwd_we[i]                     = we;
    fwd_addr[i*ADDR_W +: ADDR_W]  = a;
    fwd_data[i*DATA_W +: DATA_W]  = d;
    fwd_ready[i]                  = rdy;
  endtask

  // Advance one rising edge and return to the falling edge for driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; e_stall = 1'b0; e_flush = 1'b0;
    e_src_addr = '0; e_reg_val = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_ready = '0;
    #1;
    chk_out("reset", 32'h0, 2'd0, 1'b0, 1'b0);
    chk("reset.fwd_count", 64'(fwd_count), 64'd0);
    chk("reset.stall_count", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // No match
    e_src_addr = 5'd5; e_reg_val = 32'h11;
    #1 chk_out("nomatch", 32'h11, 2'd0, 1'b0, 1'b0);
    tick();

    // Priority: nearest source wins
    set_src(0, 1'b1, 5'd5, 32'hAA, 1'b1);
    set_src(1, 1'b1, 5'd5, 32'hBB, 1'b1);
    #1 chk_out("prio_both", 32'hAA, 2'd1, 1'b0, 1'b0);
    tick();
    fwd_we[0] = 1'b0;
    #1 chk_out("prio_src1", 32'hBB, 2'd2, 1'b0, 1'b0);
    tick();

    // Load-use: nearest producer not ready, farther ignored
    set_src(0, 1'b1, 5'd5, 32'h0, 1'b0);
    #1 chk_out("loaduse", 32'h11, 2'd0, 1'b1, 1'b0);
    tick();
    set_src(0, 1'b1, 5'd5, 32'hCC, 1'b1);
    #1 chk_out("loaduse_ready", 32'hCC, 2'd1, 1'b0, 1'b0);
    tick();

    // Stall hold
    e_stall = 1'b1;
    set_src(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_src(1, 1'b1, 5'd5, 32'hDD, 1'b1);
    #1 chk_out("hold_cap", 32'hDD, 2'd2, 1'b0, 1'b0);
    tick();
    fwd_we = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chk_out($sformatf("hold_stalled%0d", k), 32'hDD, 2'd3, 1'b0, 1'b1);
      tick();
    end
    e_stall = 1'b0;
    #1 chk_out("hold_release", 32'hDD, 2'd3, 1'b0, 1'b1);
    tick();
    #1 chk_out("hold_empty", 32'h11, 2'd0, 1'b0, 1'b0);

    // Address zero never forwarded
    e_src_addr = 5'd0;
    set_src(0, 1'b1, 5'd0, 32'h99, 1'b1);
    #1 chk_out("zero_addr", 32'h11, 2'd0, 1'b0, 1'b0);
    tick();

    // Flush while held, with an unready winner in the same cycle
    e_src_addr = 5'd5; e_stall = 1'b1;
    set_src(0, 1'b1, 5'd5, 32'hEE, 1'b1);
    #1 chk_out("flush_cap", 32'hEE, 2'd1, 1'b0, 1'b0);
    tick();
    fwd_ready[0] = 1'b0; e_flush = 1'b1;
    #1 chk_out("flush_held_unready", 32'hEE, 2'd3, 1'b1, 1'b1);
    tick();
    e_flush = 1'b0; e_stall = 1'b0; fwd_we = '0;
    #1 chk_out("flush_after", 32'h11, 2'd0, 1'b0, 1'b0);
    chk("fwd_count", 64'(fwd_count), 64'(EXP_FWD));
    chk("stall_count", 64'(stall_count), 64'(EXP_STALL));

    // Async reset mid-hold
    e_stall = 1'b1;
    set_src(0, 1'b1, 5'd5, 32'h77, 1'b1);
    tick();
    fwd_we = '0;
    #1 chk_out("rst_held", 32'h77, 2'd3, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1 chk_out("rst_async", 32'h11, 2'd0, 1'b0, 1'b0);
    chk("rst_async.fwd_count", 64'(fwd_count), 64'd0);
    chk("rst_async.stall_count", 64'(stall_count), 64'd0);
    set_src(0, 1'b1, 5'd5, 32'h55, 1'b1);
    #1 chk_out("rst_live_fwd", 32'h55, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
